// File: rtl/fetch_aligner_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_aligner_if
// Brief    : Program-memory read port, redirect input and decoder handshake
//            for the instruction-fetch aligner.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_aligner_if;

   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_compressed;

   // The fetch aligner itself.
   modport master (
      output mem_addr,
      input  mem_rdata,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output out_compressed
   );

   // Program memory, branch unit and decoder as seen from the other side.
   modport slave (
      input  mem_addr,
      output mem_rdata,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  out_compressed
   );

endinterface : fetch_aligner_if
`default_nettype wire

// File: rtl/fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : fetch_aligner
// Brief    : Reassembles a mixed RV32I/RVC fetch stream into one aligned
//            instruction per handshake, with redirect flushing.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_aligner #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   fetch_aligner_if.master bus
);

   localparam logic [31:0] c_STEP_HALF = 32'd2;
   localparam logic [31:0] c_STEP_WORD = 32'd4;

   // Architectural state.
   logic [31:0] r_pc;
   logic [31:0] r_fetch_addr;
   logic [15:0] r_hold_data;
   logic        r_hold_valid;

   // Next-state values.
   logic [31:0] w_pc_nxt;
   logic [31:0] w_fetch_addr_nxt;
   logic [15:0] w_hold_data_nxt;
   logic        w_hold_valid_nxt;

   // Decode of the current halfword.
   logic [15:0] w_cur_half;
   logic        w_is32;
   logic        w_bubble;
   logic        w_valid;
   logic        w_transfer;
   logic [31:0] w_instr;

   // Bit 0 of the redirect target carries no information for halfword PCs.
   logic        w_unused_redirect_lsb;
   assign w_unused_redirect_lsb = bus.redirect_pc[0];

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc         <= RESET_PC;
         r_fetch_addr <= RESET_PC;
         r_hold_data  <= 16'h0000;
         r_hold_valid <= 1'b0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_fetch_addr <= w_fetch_addr_nxt;
         r_hold_data  <= w_hold_data_nxt;
         r_hold_valid <= w_hold_valid_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Current-instruction decode and output values
   // ------------------------------------------------------------------------
   always_comb begin
      if (r_hold_valid) begin
         w_cur_half = r_hold_data;
      end else if (r_pc[1]) begin
         w_cur_half = bus.mem_rdata[31:16];
      end else begin
         w_cur_half = bus.mem_rdata[15:0];
      end

      w_is32     = (w_cur_half[1:0] == 2'b11);
      // An odd-halfword 32-bit target needs the next word before it is whole.
      w_bubble   = !r_hold_valid && r_pc[1] && w_is32;
      w_valid    = !reset && !bus.redirect_valid && !w_bubble;
      w_transfer = w_valid && bus.out_ready;

      if (!w_is32) begin
         w_instr = {16'h0000, w_cur_half};
      end else if (r_hold_valid) begin
         w_instr = {bus.mem_rdata[15:0], r_hold_data};
      end else begin
         w_instr = bus.mem_rdata;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_pc_nxt         = r_pc;
      w_fetch_addr_nxt = r_fetch_addr;
      w_hold_data_nxt  = r_hold_data;
      w_hold_valid_nxt = r_hold_valid;

      if (bus.redirect_valid) begin
         w_pc_nxt         = {bus.redirect_pc[31:1], 1'b0};
         w_fetch_addr_nxt = {bus.redirect_pc[31:2], 2'b00};
         w_hold_valid_nxt = 1'b0;
      end else if (w_bubble) begin
         w_hold_data_nxt  = bus.mem_rdata[31:16];
         w_hold_valid_nxt = 1'b1;
         w_fetch_addr_nxt = r_fetch_addr + c_STEP_WORD;
      end else if (w_transfer) begin
         w_pc_nxt = r_pc + (w_is32 ? c_STEP_WORD : c_STEP_HALF);
         if (r_hold_valid) begin
            if (w_is32) begin
               // Upper half of the freshly consumed word starts the next instruction.
               w_hold_data_nxt  = bus.mem_rdata[31:16];
               w_fetch_addr_nxt = r_fetch_addr + c_STEP_WORD;
            end else begin
               w_hold_valid_nxt = 1'b0;
            end
         end else begin
            w_fetch_addr_nxt = r_fetch_addr + c_STEP_WORD;
            if (!w_is32 && !r_pc[1]) begin
               w_hold_data_nxt  = bus.mem_rdata[31:16];
               w_hold_valid_nxt = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output drive
   // ------------------------------------------------------------------------
   always_comb begin
      bus.mem_addr       = r_fetch_addr;
      bus.out_pc         = r_pc;
      bus.out_valid      = w_valid;
      bus.out_instr      = w_valid ? w_instr : NOP_INSTR;
      bus.out_compressed = w_valid && !w_is32;
   end

endmodule : fetch_aligner
`default_nettype wire

// File: tb/tb_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_aligner
// Brief    : Directed and randomized self-checking bench for fetch_aligner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_aligner;

   localparam logic [31:0] c_RST_PC = 32'h0000_0000;
   localparam logic [31:0] c_NOP    = 32'h0000_0013;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_aligner_if bus ();

   logic [31:0] mem [0:63];
   assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

   fetch_aligner #(
      .RESET_PC  (c_RST_PC),
      .NOP_INSTR (c_NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference view of the program: instructions decoded straight from memory.
   function automatic logic [15:0] half_at(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[7:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   function automatic logic is_wide(input logic [31:0] a);
      logic [15:0] h;
      h = half_at(a);
      return h[1:0] == 2'b11;
   endfunction

   function automatic logic [31:0] ref_instr(input logic [31:0] a);
      if (is_wide(a)) return {half_at(a + 32'd2), half_at(a)};
      return {16'h0000, half_at(a)};
   endfunction

   task automatic load_plan();
      for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
      mem[0] = 32'h0020_0093;
      mem[1] = 32'h0593_4529;
      mem[2] = 32'h061D_0050;
   endtask

   // Reset, release, and leave time 1 unit into the first post-reset cycle.
   task automatic start();
      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      load_plan();
      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_instr !== c_NOP || bus.out_compressed !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b i=%h c=%b, need v=0 i=%h c=0",
                  bus.out_valid, bus.out_instr, bus.out_compressed, c_NOP);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0020_0093 || bus.out_pc !== 32'h0 ||
          bus.out_compressed !== 1'b0 || bus.mem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL first_fetch: got v=%b i=%h pc=%h c=%b a=%h, need v=1 i=00200093 pc=0 c=0 a=0",
                  bus.out_valid, bus.out_instr, bus.out_pc, bus.out_compressed, bus.mem_addr);
      end
      tick();
      n_checks++;
      if (bus.mem_addr !== 32'h4) begin
         n_fail++;
         $display("FAIL addr_after_first: got %h need 00000004", bus.mem_addr);
      end
   endtask

   task automatic test_stream();
      logic [31:0] e_pc [4]    = '{32'h0, 32'h4, 32'h6, 32'hA};
      logic [31:0] e_in [4]    = '{32'h0020_0093, 32'h0000_4529, 32'h0050_0593, 32'h0000_061D};
      logic        e_c  [4]    = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] e_a  [4]    = '{32'h0, 32'h4, 32'h8, 32'hC};
      load_plan();
      start();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== e_pc[i] || bus.out_instr !== e_in[i] ||
             bus.out_compressed !== e_c[i] || bus.mem_addr !== e_a[i]) begin
            n_fail++;
            $display("FAIL stream[%0d]: got v=%b pc=%h i=%h c=%b a=%h, need v=1 pc=%h i=%h c=%b a=%h",
                     i, bus.out_valid, bus.out_pc, bus.out_instr, bus.out_compressed, bus.mem_addr,
                     e_pc[i], e_in[i], e_c[i], e_a[i]);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      load_plan();
      start();
      tick();
      tick();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h6 || bus.out_instr !== 32'h0050_0593 ||
             bus.mem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL stall[%0d]: got v=%b pc=%h i=%h a=%h, need v=1 pc=6 i=00500593 a=8",
                     i, bus.out_valid, bus.out_pc, bus.out_instr, bus.mem_addr);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.out_pc !== 32'h6 || bus.out_instr !== 32'h0050_0593) begin
         n_fail++;
         $display("FAIL stall_resume: got pc=%h i=%h need pc=6 i=00500593", bus.out_pc, bus.out_instr);
      end
      tick();
      n_checks++;
      if (bus.out_pc !== 32'hA || bus.out_instr !== 32'h0000_061D || bus.out_compressed !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_after: got pc=%h i=%h c=%b need pc=a i=0000061d c=1",
                  bus.out_pc, bus.out_instr, bus.out_compressed);
      end
   endtask

   task automatic test_redirect_odd();
      load_plan();
      start();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h6;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_instr !== c_NOP) begin
         n_fail++;
         $display("FAIL redir_cycle: got v=%b i=%h need v=0 i=%h", bus.out_valid, bus.out_instr, c_NOP);
      end
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.mem_addr !== 32'h4) begin
         n_fail++;
         $display("FAIL redir_bubble: got v=%b a=%h need v=0 a=4", bus.out_valid, bus.mem_addr);
      end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h6 || bus.out_instr !== 32'h0050_0593 ||
          bus.out_compressed !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_target: got v=%b pc=%h i=%h c=%b need v=1 pc=6 i=00500593 c=0",
                  bus.out_valid, bus.out_pc, bus.out_instr, bus.out_compressed);
      end
   endtask

   task automatic test_redirect_priority();
      load_plan();
      start();
      tick();
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_prio_cycle: got v=%b need v=0", bus.out_valid);
      end
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0020_0093) begin
         n_fail++;
         $display("FAIL redir_prio_next: got v=%b pc=%h i=%h need v=1 pc=0 i=00200093",
                  bus.out_valid, bus.out_pc, bus.out_instr);
      end
   endtask

   task automatic test_reset_midstream();
      load_plan();
      start();
      tick();
      tick();
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_instr !== c_NOP) begin
         n_fail++;
         $display("FAIL midreset_during: got v=%b i=%h need v=0 i=%h", bus.out_valid, bus.out_instr, c_NOP);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== c_RST_PC || bus.out_instr !== 32'h0020_0093) begin
         n_fail++;
         $display("FAIL midreset_after: got v=%b pc=%h i=%h need v=1 pc=%h i=00200093",
                  bus.out_valid, bus.out_pc, bus.out_instr, c_RST_PC);
      end
   endtask

   task automatic test_random();
      logic [31:0] m_pc;
      logic        m_bubble;
      logic        redir;
      logic        exp_v;
      logic [31:0] rp;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      start();
      m_pc = c_RST_PC;
      m_bubble = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         redir = ($urandom_range(0, 15) == 0);
         rp = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_00FF);
         bus.redirect_valid = redir;
         bus.redirect_pc = rp;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_v = !redir && !m_bubble;
         n_checks++;
         if (bus.out_valid !== exp_v || bus.mem_addr[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL rand_valid cyc%0d: got v=%b a=%h need v=%b a[1:0]=0",
                     cyc, bus.out_valid, bus.mem_addr, exp_v);
         end
         n_checks++;
         if (exp_v) begin
            if (bus.out_pc !== m_pc || bus.out_instr !== ref_instr(m_pc) ||
                bus.out_compressed !== !is_wide(m_pc)) begin
               n_fail++;
               $display("FAIL rand_instr cyc%0d: got pc=%h i=%h c=%b need pc=%h i=%h c=%b",
                        cyc, bus.out_pc, bus.out_instr, bus.out_compressed,
                        m_pc, ref_instr(m_pc), !is_wide(m_pc));
            end
         end else if (bus.out_instr !== c_NOP || bus.out_compressed !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_idle cyc%0d: got i=%h c=%b need i=%h c=0",
                     cyc, bus.out_instr, bus.out_compressed, c_NOP);
         end
         if (redir) begin
            m_pc = {rp[31:1], 1'b0};
            m_bubble = m_pc[1] && is_wide(m_pc);
         end else if (m_bubble) begin
            m_bubble = 1'b0;
         end else if (bus.out_ready) begin
            m_pc = m_pc + (is_wide(m_pc) ? 32'd4 : 32'd2);
         end
         @(negedge clk);
      end
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.out_ready = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_odd();
      test_redirect_priority();
      test_reset_midstream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fetch_aligner
`default_nettype wire
